// File: rtl/ray_pixel_scheduler_if.sv
// ray_pixel_scheduler_if
// Pixel-issue handshake between the scheduler and the ray core.
//   ray_valid : scheduler -> core, image_x/image_y hold a pixel to issue
//   ray_ready : core -> scheduler, core accepts the pixel this cycle
//   image_x   : scheduler -> core, pixel column (zero-extended to 11 bits)
//   image_y   : scheduler -> core, pixel row (zero-extended to 11 bits)
// A transfer happens on every cycle where ray_valid & ray_ready.
interface ray_pixel_scheduler_if;
    logic        ray_valid;
    logic        ray_ready;
    logic [10:0] image_x;
    logic [10:0] image_y;

    modport master (
        output ray_valid,
        output image_x,
        output image_y,
        input  ray_ready
    );

    modport slave (
        input  ray_valid,
        input  image_x,
        input  image_y,
        output ray_ready
    );
endinterface

// File: rtl/ray_pixel_scheduler.sv
// ray_pixel_scheduler
// Walks a WIDTH x HEIGHT frame in raster order and issues one pixel coordinate per
// accepted handshake to the ray core, waits for the write-back of the last pixel,
// then flips the double-buffered frame buffer and hands the finished frame to the
// display. Optionally chains frames back-to-back.
// Ports:
//   i_clk          : clock, rising edge
//   i_rst          : synchronous active-high reset
//   i_start        : strobe, start one frame (only honoured in IDLE)
//   i_continuous   : sampled in SWAP, 1 = immediately start the next frame
//   i_frame_done   : strobe, last pixel of the frame written back
//   ray_if         : pixel handshake towards the ray core (master side)
//   o_buffer_sel   : frame-buffer half being written
//   o_frame_ready  : one-cycle pulse when a frame is handed to the display
//   o_frame_count  : completed frames, wraps at 16 bits
//   o_busy         : 1 whenever the scheduler is not idle
//   o_seq_error    : sticky, frame_done seen outside DRAIN
// All outputs are registered.
module ray_pixel_scheduler #(
    parameter int unsigned WIDTH  = 640,
    parameter int unsigned HEIGHT = 480
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_start,
    input  logic                         i_continuous,
    input  logic                         i_frame_done,
    ray_pixel_scheduler_if.master        ray_if,
    output logic                         o_buffer_sel,
    output logic                         o_frame_ready,
    output logic [15:0]                  o_frame_count,
    output logic                         o_busy,
    output logic                         o_seq_error
);

    localparam int unsigned XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [XW-1:0] XLast = XW'(WIDTH - 1);
    localparam logic [YW-1:0] YLast = YW'(HEIGHT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StSwap
    } state_e;

    state_e          r_state;
    logic [XW-1:0]   r_x;
    logic [YW-1:0]   r_y;
    logic            r_ray_valid;
    logic            r_buffer_sel;
    logic            r_frame_ready;
    logic [15:0]     r_frame_count;
    logic            r_busy;
    logic            r_seq_error;

    state_e          w_state_nxt;
    logic [XW-1:0]   w_x_nxt;
    logic [YW-1:0]   w_y_nxt;
    logic            w_ray_valid_nxt;
    logic            w_buffer_sel_nxt;
    logic            w_frame_ready_nxt;
    logic [15:0]     w_frame_count_nxt;
    logic            w_busy_nxt;
    logic            w_seq_error_nxt;
    logic            w_xfer;

    assign w_xfer = r_ray_valid & ray_if.ray_ready;

    always_comb begin
        w_state_nxt       = r_state;
        w_x_nxt           = r_x;
        w_y_nxt           = r_y;
        w_ray_valid_nxt   = r_ray_valid;
        w_buffer_sel_nxt  = r_buffer_sel;
        w_frame_ready_nxt = 1'b0;
        w_frame_count_nxt = r_frame_count;
        w_seq_error_nxt   = r_seq_error;

        case (r_state)
            StIdle: begin
                // frame_done here is a protocol error, but a coincident start still runs
                if (i_frame_done) begin
                    w_seq_error_nxt = 1'b1;
                end
                if (i_start) begin
                    w_state_nxt     = StIssue;
                    w_x_nxt         = '0;
                    w_y_nxt         = '0;
                    w_ray_valid_nxt = 1'b1;
                end
            end

            StIssue: begin
                if (i_frame_done) begin
                    w_seq_error_nxt = 1'b1;
                end
                if (w_xfer) begin
                    if (r_x != XLast) begin
                        w_x_nxt = r_x + XW'(1);
                    end else if (r_y != YLast) begin
                        w_x_nxt = '0;
                        w_y_nxt = r_y + YW'(1);
                    end else begin
                        w_ray_valid_nxt = 1'b0;
                        w_state_nxt     = StDrain;
                    end
                end
            end

            StDrain: begin
                // Buffer flip and frame hand-off become visible during the SWAP cycle
                if (i_frame_done) begin
                    w_state_nxt       = StSwap;
                    w_buffer_sel_nxt  = ~r_buffer_sel;
                    w_frame_count_nxt = r_frame_count + 16'd1;
                    w_frame_ready_nxt = 1'b1;
                end
            end

            StSwap: begin
                if (i_frame_done) begin
                    w_seq_error_nxt = 1'b1;
                end
                if (i_continuous) begin
                    w_state_nxt     = StIssue;
                    w_x_nxt         = '0;
                    w_y_nxt         = '0;
                    w_ray_valid_nxt = 1'b1;
                end else begin
                    w_state_nxt = StIdle;
                end
            end

            default: begin
                w_state_nxt     = StIdle;
                w_ray_valid_nxt = 1'b0;
            end
        endcase

        w_busy_nxt = (w_state_nxt != StIdle);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= StIdle;
            r_x           <= '0;
            r_y           <= '0;
            r_ray_valid   <= 1'b0;
            r_buffer_sel  <= 1'b0;
            r_frame_ready <= 1'b0;
            r_frame_count <= 16'd0;
            r_busy        <= 1'b0;
            r_seq_error   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_x           <= w_x_nxt;
            r_y           <= w_y_nxt;
            r_ray_valid   <= w_ray_valid_nxt;
            r_buffer_sel  <= w_buffer_sel_nxt;
            r_frame_ready <= w_frame_ready_nxt;
            r_frame_count <= w_frame_count_nxt;
            r_busy        <= w_busy_nxt;
            r_seq_error   <= w_seq_error_nxt;
        end
    end

    assign ray_if.ray_valid = r_ray_valid;
    assign ray_if.image_x   = 11'(r_x);
    assign ray_if.image_y   = 11'(r_y);
    assign o_buffer_sel     = r_buffer_sel;
    assign o_frame_ready    = r_frame_ready;
    assign o_frame_count    = r_frame_count;
    assign o_busy           = r_busy;
    assign o_seq_error      = r_seq_error;

endmodule

// File: tb/tb_ray_pixel_scheduler.sv
// tb_ray_pixel_scheduler
// Randomised bench for ray_pixel_scheduler. The expected pixel stream is a raster-order
// queue built up front; frame-level state (buffer half, frame count, error flag) is
// kept as plain counters updated at the frame events the bench itself creates.
module tb_ray_pixel_scheduler;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int BW = 640;
    localparam int BH = 2;

    logic        clk;
    logic        rst;
    logic        start;
    logic        continuous;
    logic        frame_done;
    logic        buffer_sel;
    logic        frame_ready;
    logic [15:0] frame_count;
    logic        busy;
    logic        seq_error;

    logic        big_start;
    logic        big_zero;
    logic        big_buffer_sel;
    logic        big_frame_ready;
    logic [15:0] big_frame_count;
    logic        big_busy;
    logic        big_seq_error;

    int n_tests;
    int n_fail;

    // Frame-level reference state
    int exp_buf;
    int exp_cnt;
    int exp_err;

    ray_pixel_scheduler_if rif ();
    ray_pixel_scheduler_if big_if ();

    ray_pixel_scheduler #(.WIDTH(W), .HEIGHT(H)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_continuous  (continuous),
        .i_frame_done  (frame_done),
        .ray_if        (rif),
        .o_buffer_sel  (buffer_sel),
        .o_frame_ready (frame_ready),
        .o_frame_count (frame_count),
        .o_busy        (busy),
        .o_seq_error   (seq_error)
    );

    // Wide-row instance exercises coordinates beyond 4 bits and the 11-bit outputs
    ray_pixel_scheduler #(.WIDTH(BW), .HEIGHT(BH)) dut_big (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (big_start),
        .i_continuous  (big_zero),
        .i_frame_done  (big_zero),
        .ray_if        (big_if),
        .o_buffer_sel  (big_buffer_sel),
        .o_frame_ready (big_frame_ready),
        .o_frame_count (big_frame_count),
        .o_busy        (big_busy),
        .o_seq_error   (big_seq_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state();
        check_eq("rst_valid", 32'(rif.ray_valid), 0);
        check_eq("rst_x", 32'(rif.image_x), 0);
        check_eq("rst_y", 32'(rif.image_y), 0);
        check_eq("rst_buf", 32'(buffer_sel), 0);
        check_eq("rst_frame_ready", 32'(frame_ready), 0);
        check_eq("rst_count", 32'(frame_count), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_err", 32'(seq_error), 0);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_buf = 0;
        exp_cnt = 0;
        exp_err = 0;
    endtask

    task automatic start_frame(input bit with_done);
        start      = 1'b1;
        frame_done = with_done;
        tick();
        start      = 1'b0;
        frame_done = 1'b0;
        if (with_done) exp_err = 1;
        check_eq("start_valid", 32'(rif.ray_valid), 1);
        check_eq("start_x", 32'(rif.image_x), 0);
        check_eq("start_y", 32'(rif.image_y), 0);
        check_eq("start_busy", 32'(busy), 1);
        check_eq("start_err", 32'(seq_error), 32'(exp_err));
    endtask

    // Issue pixels with random backpressure; stop_after < 0 runs the whole frame.
    task automatic issue_frame(input int ready_pct, input bit inject_err, input int stop_after);
        int  q_x[$];
        int  q_y[$];
        int  budget;
        int  done;
        int  cyc;
        int  err_at;
        bit  go;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                q_x.push_back(x);
                q_y.push_back(y);
            end
        end
        budget = 2000;
        done   = 0;
        cyc    = 0;
        err_at = inject_err ? int'($urandom_range(1, W * H - 2)) : -1;
        while (q_x.size() > 0 && done != stop_after) begin
            if (budget == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL issue_budget: got %0d pending expected 0", q_x.size());
                rif.ray_ready = 1'b0;
                return;
            end
            check_eq("issue_valid", 32'(rif.ray_valid), 1);
            check_eq("issue_x", 32'(rif.image_x), q_x[0]);
            check_eq("issue_y", 32'(rif.image_y), q_y[0]);
            check_eq("issue_busy", 32'(busy), 1);
            check_eq("issue_err", 32'(seq_error), 32'(exp_err));
            rif.ray_ready = ($urandom_range(0, 99) < ready_pct);
            frame_done    = (cyc == err_at);
            go            = rif.ray_ready && rif.ray_valid;
            tick();
            frame_done = 1'b0;
            if (cyc == err_at) exp_err = 1;
            if (go) begin
                void'(q_x.pop_front());
                void'(q_y.pop_front());
                done++;
            end
            cyc++;
            budget--;
        end
        rif.ray_ready = 1'b0;
        if (q_x.size() == 0) begin
            check_eq("drain_valid", 32'(rif.ray_valid), 0);
            check_eq("drain_busy", 32'(busy), 1);
            check_eq("drain_err", 32'(seq_error), 32'(exp_err));
            if (ready_pct == 100) check_eq("no_bubble_cycles", 32'(cyc), W * H);
        end
    endtask

    task automatic drain_and_swap(input int wait_cycles, input bit poke_start, input bit cont);
        for (int i = 0; i < wait_cycles; i++) begin
            check_eq("wait_valid", 32'(rif.ray_valid), 0);
            check_eq("wait_busy", 32'(busy), 1);
            check_eq("wait_frame_ready", 32'(frame_ready), 0);
            start = poke_start;
            tick();
            start = 1'b0;
        end
        frame_done = 1'b1;
        continuous = cont;
        tick();
        frame_done = 1'b0;
        exp_buf = exp_buf ^ 1;
        exp_cnt = (exp_cnt + 1) & 16'hFFFF;
        check_eq("swap_frame_ready", 32'(frame_ready), 1);
        check_eq("swap_buf", 32'(buffer_sel), 32'(exp_buf));
        check_eq("swap_count", 32'(frame_count), 32'(exp_cnt));
        check_eq("swap_busy", 32'(busy), 1);
        check_eq("swap_valid", 32'(rif.ray_valid), 0);
        tick();
        continuous = 1'b0;
        check_eq("post_frame_ready", 32'(frame_ready), 0);
        check_eq("post_buf", 32'(buffer_sel), 32'(exp_buf));
        if (cont) begin
            check_eq("chain_valid", 32'(rif.ray_valid), 1);
            check_eq("chain_x", 32'(rif.image_x), 0);
            check_eq("chain_y", 32'(rif.image_y), 0);
            check_eq("chain_busy", 32'(busy), 1);
        end else begin
            check_eq("end_valid", 32'(rif.ray_valid), 0);
            check_eq("end_busy", 32'(busy), 0);
        end
    endtask

    initial begin
        int big_xfers;
        int big_bad;
        int ex;
        int ey;
        int last_x;
        int last_y;

        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1; start = 1'b0; continuous = 1'b0; frame_done = 1'b0;
        big_start = 1'b0; big_zero = 1'b0;
        rif.ray_ready    = 1'b0;
        big_if.ray_ready = 1'b1;
        tick();
        apply_reset();
        check_reset_state();

        // No pixel issued without a start
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("idle_valid", 32'(rif.ray_valid), 0);
        end

        // Single frame at full rate
        start_frame(1'b0);
        issue_frame(100, 1'b0, -1);
        drain_and_swap(3, 1'b0, 1'b0);
        check_eq("single_count", 32'(frame_count), 1);
        check_eq("single_buf", 32'(buffer_sel), 1);

        // Random backpressure
        for (int f = 0; f < 3; f++) begin
            start_frame(1'b0);
            issue_frame(int'($urandom_range(20, 80)), 1'b0, -1);
            drain_and_swap(int'($urandom_range(0, 4)), 1'b0, 1'b0);
        end

        // Continuous: three chained frames from reset
        apply_reset();
        check_reset_state();
        start_frame(1'b0);
        for (int f = 0; f < 3; f++) begin
            issue_frame((f == 1) ? 70 : 100, 1'b0, -1);
            drain_and_swap(int'($urandom_range(0, 3)), 1'b0, f < 2);
        end
        check_eq("cont_count", 32'(frame_count), 3);
        check_eq("cont_buf", 32'(buffer_sel), 1);

        // frame_done during ISSUE, start during DRAIN
        start_frame(1'b0);
        issue_frame(80, 1'b1, -1);
        drain_and_swap(4, 1'b1, 1'b0);
        tick();
        check_eq("nostart_valid", 32'(rif.ray_valid), 0);
        check_eq("nostart_busy", 32'(busy), 0);
        check_eq("sticky_err", 32'(seq_error), 1);

        // frame_done in IDLE: flag only
        apply_reset();
        check_reset_state();
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        exp_err = 1;
        check_eq("idle_done_err", 32'(seq_error), 1);
        check_eq("idle_done_busy", 32'(busy), 0);

        // start and frame_done together in IDLE
        apply_reset();
        start_frame(1'b1);

        // Reset mid-frame after 5 transfers, with start/frame_done also asserted
        issue_frame(100, 1'b0, 5);
        rst = 1'b1; start = 1'b1; frame_done = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0; frame_done = 1'b0;
        exp_buf = 0; exp_cnt = 0; exp_err = 0;
        check_reset_state();
        for (int i = 0; i < 3; i++) begin
            rif.ray_ready = 1'b1;
            tick();
            check_eq("post_rst_idle", 32'(rif.ray_valid), 0);
        end
        rif.ray_ready = 1'b0;
        start_frame(1'b0);
        issue_frame(60, 1'b0, -1);
        drain_and_swap(0, 1'b0, 1'b0);

        // Wide frame on the second instance, full rate
        big_start = 1'b1;
        tick();
        big_start = 1'b0;
        big_xfers = 0; big_bad = 0; ex = 0; ey = 0; last_x = -1; last_y = -1;
        for (int c = 0; c < BW * BH + 20; c++) begin
            if (big_if.ray_valid) begin
                if (int'(big_if.image_x) != ex || int'(big_if.image_y) != ey) big_bad++;
                last_x = int'(big_if.image_x);
                last_y = int'(big_if.image_y);
                big_xfers++;
                ex++;
                if (ex == BW) begin
                    ex = 0;
                    ey++;
                end
            end
            tick();
        end
        check_eq("big_xfers", 32'(big_xfers), BW * BH);
        check_eq("big_order_errors", 32'(big_bad), 0);
        check_eq("big_last_x", 32'(last_x), BW - 1);
        check_eq("big_last_y", 32'(last_y), BH - 1);
        check_eq("big_drain_busy", 32'(big_busy), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ray_pixel_scheduler.md
RAY_PIXEL_SCHEDULER -- requirements
Module: ray_pixel_scheduler

Interface
REQ-001 Parameter WIDTH, default 640, SHALL set pixels per row.
REQ-002 Parameter HEIGHT, default 480, SHALL set rows per frame.
REQ-003 Port clk, input, 1, SHALL be the single clock; all logic is rising-edge.
REQ-004 Port rst, input, 1, SHALL be the synchronous, active-high reset.
REQ-005 Port start, input, 1, SHALL be a strobe that requests rendering of one frame.
REQ-006 Port continuous, input, 1, SHALL, when 1, chain frames back-to-back; it is sampled in SWAP.
REQ-007 Port ray_valid, output, 1, SHALL flag that image_x/image_y hold a pixel to be issued to the ray core.
REQ-008 Port ray_ready, input, 1, SHALL flag that the ray core accepts the pixel this cycle.
REQ-009 Ports image_x and image_y, output, 11 each, SHALL carry the pixel coordinate.
REQ-010 Port frame_done, input, 1, SHALL be the write-back strobe for "last pixel of frame received".
REQ-011 Port buffer_sel, output, 1, SHALL select the frame-buffer half being written; the display reads the other half.
REQ-012 Port frame_ready, output, 1, SHALL pulse for one cycle when a completed frame is handed to the display.
REQ-013 Port frame_count, output, 16, SHALL count completed frames.
REQ-014 Port busy, output, 1, SHALL be 1 in every state except IDLE.
REQ-015 Port seq_error, output, 1, SHALL be a sticky flag for a protocol violation.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE, DRAIN, and SWAP; all outputs SHALL be registered.
REQ-017 IDLE: when start=1, the FSM SHALL load x=0 and y=0 and enter ISSUE, with ray_valid=1 on the next cycle.
REQ-018 ISSUE: ray_valid SHALL be 1, and image_x/image_y SHALL stay stable while ray_valid=1 and ray_ready=0.
REQ-019 A transfer SHALL occur on ray_valid & ray_ready, and SHALL accept at most one pixel per cycle; with ray_ready held at 1, a frame SHALL issue at a rate of one pixel per cycle with no bubbles.
REQ-020 On a transfer with x<WIDTH-1, the next coordinate SHALL be (x+1, y).
REQ-021 On a transfer with x=WIDTH-1 and y<HEIGHT-1, the next coordinate SHALL be (0, y+1).
REQ-022 On a transfer of (WIDTH-1, HEIGHT-1), the next cycle SHALL have ray_valid=0 and the FSM SHALL enter DRAIN; the coordinate outputs SHALL be don't-care while ray_valid=0.
REQ-023 DRAIN: the FSM SHALL wait for frame_done, with no timeout, and on frame_done=1 SHALL enter SWAP.
REQ-024 SWAP lasts one cycle and SHALL: toggle buffer_sel; increment frame_count (wrap 0xFFFF to 0); pulse frame_ready; then enter ISSUE with x=0, y=0 if continuous=1, else enter IDLE.
REQ-025 A start strobe in any state other than IDLE SHALL be ignored and not queued.
REQ-026 A frame_done strobe in IDLE, ISSUE, or SWAP SHALL set seq_error and SHALL NOT otherwise change the state.
REQ-027 seq_error SHALL clear only on rst.
REQ-028 If start and frame_done arrive together in IDLE, the FSM SHALL start the frame and SHALL set seq_error.
REQ-029 Coordinate counters SHALL be wide enough for WIDTH-1 and HEIGHT-1 and SHALL be zero-extended to 11 bits.

Reset
REQ-030 On rst=1, from any state including mid-frame, the next cycle SHALL have: state IDLE, ray_valid=0, image_x=0, image_y=0, buffer_sel=0, frame_ready=0, frame_count=0, busy=0, seq_error=0.
REQ-031 rst SHALL take priority over every other input in the same cycle.
REQ-032 After reset, no pixel SHALL be issued until a new start strobe is received.

Verification (WIDTH=4, HEIGHT=3 unless noted)
REQ-033 Single frame: start pulse, ray_ready=1 → 12 transfers in raster order (0,0)..(3,2), one per cycle; ray_valid then drops; frame_done → frame_ready pulse; buffer_sel=1; frame_count=1; busy=0.
REQ-034 Backpressure: ray_ready toggles randomly → coordinates hold while stalled; exactly 12 unique transfers in order; no duplicates or skips.
REQ-035 Continuous: continuous=1, 3 frames → buffer_sel sequence 1,0,1; frame_count=3; the first pixel of the next frame is valid the cycle after SWAP.
REQ-036 Protocol errors: frame_done pulsed during ISSUE → seq_error=1 and pixel issuing continues unchanged; a start pulse during DRAIN has no effect.
REQ-037 Reset mid-frame: rst asserted after 5 transfers → all outputs match REQ-030; a new start restarts at (0,0).
REQ-038 Default parameters: a full 640x480 frame with ray_ready=1 → 307200 transfers; the last is (639,479).
